// File: rtl/axil_rd_responder.sv
// AXI-lite read-only slave responder backed by a loadable word store.
// Reads complete with one cycle of latency and sustain one beat per cycle.
// Build option: define AXIL_RD_RESPONDER_RANGE_CHECK_EN to answer reads whose
// word index falls outside the store with SLVERR and zero data. When it is not
// defined, the index wraps modulo DEPTH and every response is OKAY.
module axil_rd_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic [31:0]              rd_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The only state is whether a response is being presented.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_full;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_oob;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            rd_resp;
  logic                  ar_hs;
  logic                  r_hs;

  assign word_full = s_axil_araddr >> OFF_W;
  assign rd_idx    = word_full[IDX_W-1:0];
  assign rd_oob    = |(word_full >> IDX_W);

  assign s_axil_rvalid  = (state == ST_RESP);
  assign s_axil_arready = !s_axil_rvalid || s_axil_rready;
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign r_hs           = s_axil_rvalid && s_axil_rready;

`ifdef AXIL_RD_RESPONDER_RANGE_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^s_axil_arprot;

  // Select read data and response, rejecting indices beyond the store.
  always_comb begin
    rd_word = mem[rd_idx];
    rd_resp = RESP_OKAY;
    if (rd_oob) begin
      rd_word = '0;
      rd_resp = RESP_SLVERR;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{s_axil_arprot, rd_oob};

  // Select read data; the index wraps modulo DEPTH and all reads are OKAY.
  always_comb begin
    rd_word = mem[rd_idx];
    rd_resp = RESP_OKAY;
  end
`endif

  // Backing-store write port; not reset so contents survive rst. Because the
  // response register samples the pre-edge array, a same-cycle load and read
  // of one word returns the old value.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Response register: load on AR handshake, retire on R handshake, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      state        <= ST_RESP;
      s_axil_rdata <= rd_word;
      s_axil_rresp <= rd_resp;
    end else if (r_hs) begin
      state        <= ST_IDLE;
    end
  end

  // Count completed R beats; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
    end else if (r_hs) begin
      rd_count <= rd_count + 32'd1;
    end
  end

endmodule

// File: doc/axil_rd_responder.md
AXIL_RD_RESPONDER -- requirements
Module: axil_rd_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: AXI-lite read data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI-lite byte-address width.
REQ-003 SHALL have parameter DEPTH, default 256: number of DATA_WIDTH words in backing store; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port s_axil_araddr, input, ADDR_WIDTH: read byte address.
REQ-007 SHALL have port s_axil_arprot, input, 3: accepted and ignored.
REQ-008 SHALL have ports s_axil_arvalid (input, 1) and s_axil_arready (output, 1): AR handshake.
REQ-009 SHALL have port s_axil_rdata, output, DATA_WIDTH: read data.
REQ-010 SHALL have port s_axil_rresp, output, 2: OKAY 2'b00 / SLVERR 2'b10.
REQ-011 SHALL have ports s_axil_rvalid (output, 1) and s_axil_rready (input, 1): R handshake.
REQ-012 SHALL have port load_en, input, 1: backing-store write strobe.
REQ-013 SHALL have port load_addr, input, $clog2(DEPTH): word index to write.
REQ-014 SHALL have port load_data, input, DATA_WIDTH: word to write.
REQ-015 SHALL have port rd_count, output, 32: completed R beats since reset.

Function
REQ-016 SHALL be the slave-side responder for the MCU AXI-lite read masters (data, grid, scale), one instance per channel.
REQ-017 SHALL compute word index = s_axil_araddr >> $clog2(DATA_WIDTH/8); low byte-offset bits ignored, unaligned reads return OKAY.
REQ-018 SHALL drive s_axil_arready = !s_axil_rvalid || s_axil_rready (combinational); at most one response outstanding.
REQ-019 SHALL, on AR handshake in cycle N, present rdata/rresp with rvalid=1 in cycle N+1 (1-cycle latency).
REQ-020 SHALL sustain one read per cycle while rready is held high.
REQ-021 SHALL hold rdata, rresp, rvalid stable while rvalid=1 and rready=0.
REQ-022 SHALL clear rvalid on R handshake unless a new AR handshake occurs in the same cycle, in which case rvalid stays 1 with new data.
REQ-023 SHALL write load_data to load_addr on a clk edge with load_en=1.
REQ-024 SHALL give read-first behaviour when load and AR handshake target the same word in the same cycle: response carries old data.
REQ-025 SHALL increment rd_count by 1 per R handshake, wrapping 0xFFFFFFFF -> 0.
REQ-026 SHALL have no state machine beyond the rvalid flag: states IDLE (rvalid=0) and RESP (rvalid=1), transitions per REQ-019/022.

Reset
REQ-027 SHALL, with rst=1, force rvalid=0, rresp=2'b00, rdata=0, rd_count=0 on the next edge; arready is then 1.
REQ-028 SHALL discard a pending response when reset is asserted mid-transfer; no beat is reissued after reset.
REQ-029 SHALL NOT clear or alter backing-store contents on reset; load writes remain accepted during reset.

Configuration
REQ-030 SHALL honour macro AXIL_RD_RESPONDER_RANGE_CHECK_EN.
- Defined: index >= DEPTH, i.e. any set address bit above the word-index field, returns rresp=2'b10 and rdata=0.
- Undefined: index is taken modulo DEPTH and rresp is always 2'b00.

Verification
REQ-031 SHALL cover: load words 0..3 = 0x1111..0x4444, rready=1, AR 0x0,0x2,0x4,0x6 back-to-back -> rvalid 4 consecutive cycles, data 0x1111,0x2222,0x3333,0x4444, rd_count=4.
REQ-032 SHALL cover: AR 0x2 with rready=0 for 5 cycles -> rvalid=1 with rdata stable 0x2222, arready=0; rready=1 -> beat completes, arready=1.
REQ-033 SHALL cover: AR 0x200, DEPTH=256, DATA_WIDTH=16 -> with macro rresp=2'b10, rdata=0; without macro rresp=2'b00, rdata=word 0.
REQ-034 SHALL cover: same cycle load word 1 = 0xBEEF and AR 0x2 -> response 0x2222; next AR 0x2 -> 0xBEEF.
REQ-035 SHALL cover: rst pulsed while rvalid=1 -> rvalid=0, rd_count=0 next cycle; then AR 0x0 -> 0x1111, which confirms memory is retained.
REQ-036 SHALL cover: AR 0x3 (unaligned) -> rresp=2'b00, rdata=word 1.
